control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 178 +++++++++++++++++
 tb/tb_control_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Control sequencer: steps the fetch/execute cycle and decodes each step into the ALUSystem control word.
// Optional single-step gating of FETCH_L is enabled by defining CU_STEP_EN (adds the Step input).
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
`ifdef CU_STEP_EN
    input  logic        Step,
`endif
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_Flags,
    output logic [40:0] Ctrl,
    output logic [2:0]  SC,
    output logic        Halted,
    output logic        Illegal
);

    // State encodings double as the visible SC value.
    typedef enum logic [2:0] {
        S_FETCH_L = 3'd0,
        S_FETCH_H = 3'd1,
        S_EXEC    = 3'd2,
        S_EXEC2   = 3'd3,
        S_INIT    = 3'd4,
        S_HALT    = 3'd7
    } state_t;

    typedef struct packed {
        logic [2:0] rf_o1_sel;
        logic [2:0] rf_o2_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_a_sel;
        logic [1:0] arf_out_b_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_rsel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_fun_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_BRA = 4'h4;
    localparam logic [3:0] OP_BNE = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'h8;

    state_t      state;
    ctrl_t       ctrl_w;
    logic [3:0]  opcode;
    logic [1:0]  rd, rs1, rs2;
    logic [3:0]  rd_onehot;
    logic        flag_z;
    logic        fetch_go;
    logic        unused_bits;

    assign opcode    = IR_Out[15:12];
    assign rd        = IR_Out[11:10];
    assign rs1       = IR_Out[9:8];
    assign rs2       = IR_Out[7:6];
    assign rd_onehot = 4'b1000 >> rd;
    assign flag_z    = ALU_Flags[3];
    // Immediate bits and C/N/O flags feed the datapath directly, not this decoder.
    assign unused_bits = ^{IR_Out[5:0], ALU_Flags[2:0]};

`ifdef CU_STEP_EN
    assign fetch_go = Step;
`else
    assign fetch_go = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_INIT;
        end else begin
            case (state)
                S_INIT:    state <= S_FETCH_L;
                S_FETCH_L: if (fetch_go) state <= S_FETCH_H;
                S_FETCH_H: state <= S_EXEC;
                S_EXEC: begin
                    if (opcode == OP_LD)       state <= S_EXEC2;
                    else if (opcode == OP_HLT) state <= S_HALT;
                    else                       state <= S_FETCH_L;
                end
                S_EXEC2:   state <= S_FETCH_L;
                S_HALT:    state <= S_HALT;
                default:   state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        // NOTE: start from the IDLE word so every path assigns every bit and no latch is inferred.
        ctrl_w        = '0;
        ctrl_w.mem_cs = 1'b1;
        Illegal       = 1'b0;
        case (state)
            S_INIT: begin
                ctrl_w.rf_rsel     = 4'b1111;
                ctrl_w.rf_tsel     = 4'b1111;
                ctrl_w.rf_fun_sel  = 2'b11;
                ctrl_w.arf_rsel    = 4'b1110;
                ctrl_w.arf_fun_sel = 2'b11;
            end
            S_FETCH_L, S_FETCH_H: begin
                if (state == S_FETCH_H || fetch_go) begin
                    ctrl_w.mem_cs      = 1'b0;
                    ctrl_w.ir_enable   = 1'b1;
                    ctrl_w.ir_fun_sel  = 2'b10;
                    ctrl_w.ir_lh       = (state == S_FETCH_H);
                    ctrl_w.arf_rsel    = 4'b1000;
                    ctrl_w.arf_fun_sel = 2'b01;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_NOP, OP_HLT: ;
                    OP_LDI: begin
                        ctrl_w.mux_a_sel  = 2'b01;
                        ctrl_w.rf_fun_sel = 2'b10;
                        ctrl_w.rf_rsel    = rd_onehot;
                    end
                    OP_ADD, OP_AND: begin
                        ctrl_w.rf_o1_sel   = {1'b1, rs1};
                        ctrl_w.rf_o2_sel   = {1'b1, rs2};
                        ctrl_w.alu_fun_sel = (opcode == OP_ADD) ? 4'b0100 : 4'b0111;
                        ctrl_w.rf_fun_sel  = 2'b10;
                        ctrl_w.rf_rsel     = rd_onehot;
                    end
                    OP_BRA, OP_BNE: begin
                        // BNE with Z set falls through as the IDLE word.
                        if (opcode == OP_BRA || !flag_z) begin
                            ctrl_w.arf_fun_sel = 2'b10;
                            ctrl_w.arf_rsel    = 4'b1000;
                            ctrl_w.mux_b_sel   = 2'b01;
                        end
                    end
                    OP_ST: begin
                        ctrl_w.rf_o1_sel     = {1'b1, rs1};
                        ctrl_w.alu_fun_sel   = 4'b0000;
                        ctrl_w.arf_out_b_sel = 2'b01;
                        ctrl_w.mem_cs        = 1'b0;
                        ctrl_w.mem_wr        = 1'b1;
                    end
                    OP_LD: begin
                        ctrl_w.arf_out_b_sel = 2'b01;
                        ctrl_w.mem_cs        = 1'b0;
                    end
                    default: Illegal = 1'b1;
                endcase
            end
            S_EXEC2: begin
                ctrl_w.arf_out_b_sel = 2'b01;
                ctrl_w.mem_cs        = 1'b0;
                ctrl_w.mux_a_sel     = 2'b10;
                ctrl_w.rf_fun_sel    = 2'b10;
                ctrl_w.rf_rsel       = rd_onehot;
            end
            default: ;
        endcase
    end

    assign Ctrl   = ctrl_w;
    assign SC     = state;
    assign Halted = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, random instruction stream
// against an instruction-level reference model, and hand-written halt/reset sequences.
module tb_control_sequencer;

    typedef struct packed {
        logic [2:0] rf_o1_sel;
        logic [2:0] rf_o2_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_a_sel;
        logic [1:0] arf_out_b_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_rsel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_fun_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  fl;
        ctrl_t       exec_w;
        ctrl_t       exec2_w;
        logic        two;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  fl;
        logic [2:0]  sc;
        ctrl_t       ctrl;
        logic        halted;
        logic        ill;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_Flags;
    logic [40:0] Ctrl;
    logic [2:0]  SC;
    logic        Halted;
    logic        Illegal;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    vec_t vecs[10];

    control_sequencer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .IR_Out   (IR_Out),
        .ALU_Flags(ALU_Flags),
        .Ctrl     (Ctrl),
        .SC       (SC),
        .Halted   (Halted),
        .Illegal  (Illegal)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t idle_w();
        ctrl_t c = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t init_w();
        ctrl_t c = idle_w();
        c.rf_rsel = 4'b1111; c.rf_tsel = 4'b1111; c.rf_fun_sel = 2'b11;
        c.arf_rsel = 4'b1110; c.arf_fun_sel = 2'b11;
        return c;
    endfunction

    function automatic ctrl_t fetch_w(input logic lh);
        ctrl_t c = idle_w();
        c.mem_cs = 1'b0; c.ir_enable = 1'b1; c.ir_fun_sel = 2'b10; c.ir_lh = lh;
        c.arf_rsel = 4'b1000; c.arf_fun_sel = 2'b01;
        return c;
    endfunction

    function automatic ctrl_t mk(input logic [2:0] o1, input logic [2:0] o2, input logic [1:0] rf_fun,
                                 input logic [3:0] rsel, input logic [3:0] alu, input logic [1:0] outb,
                                 input logic [1:0] arf_fun, input logic [3:0] arf_rsel, input logic wr,
                                 input logic cs, input logic [1:0] mux_a, input logic [1:0] mux_b);
        ctrl_t c = '0;
        c.rf_o1_sel = o1; c.rf_o2_sel = o2; c.rf_fun_sel = rf_fun; c.rf_rsel = rsel;
        c.alu_fun_sel = alu; c.arf_out_b_sel = outb; c.arf_fun_sel = arf_fun; c.arf_rsel = arf_rsel;
        c.mem_wr = wr; c.mem_cs = cs; c.mux_a_sel = mux_a; c.mux_b_sel = mux_b;
        return c;
    endfunction

    // Reference model: expands one instruction into its per-cycle expected observations.
    task automatic model_instr(input logic [15:0] ir, input logic [3:0] fl, input int halt_cycles);
        logic [3:0] sel_of_rd [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        int         op  = int'(ir[15:12]);
        logic [3:0] dst = sel_of_rd[ir[11:10]];
        logic [2:0] a   = {1'b1, ir[9:8]};
        logic [2:0] b   = {1'b1, ir[7:6]};
        ctrl_t      e   = idle_w();
        logic       ill = 1'b0;
        exp_q.push_back('{ir, fl, 3'd0, fetch_w(1'b0), 1'b0, 1'b0});
        exp_q.push_back('{ir, fl, 3'd1, fetch_w(1'b1), 1'b0, 1'b0});
        if (op == 1)                 e = mk(0, 0, 2, dst, 0, 0, 0, 0, 0, 1, 1, 0);
        else if (op == 2)            e = mk(a, b, 2, dst, 4'b0100, 0, 0, 0, 0, 1, 0, 0);
        else if (op == 3)            e = mk(a, b, 2, dst, 4'b0111, 0, 0, 0, 0, 1, 0, 0);
        else if (op == 4 || (op == 5 && fl[3] == 1'b0))
                                     e = mk(0, 0, 0, 0, 0, 0, 2, 4'b1000, 0, 1, 0, 1);
        else if (op == 6)            e = mk(a, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        else if (op == 7)            e = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        else if (op >= 9)            ill = 1'b1;
        exp_q.push_back('{ir, fl, 3'd2, e, 1'b0, ill});
        if (op == 7)
            exp_q.push_back('{ir, fl, 3'd3, mk(0, 0, 2, dst, 0, 1, 0, 0, 0, 0, 2, 0), 1'b0, 1'b0});
        if (op == 8)
            for (int k = 0; k < halt_cycles; k++)
                exp_q.push_back('{ir, fl, 3'd7, idle_w(), 1'b1, 1'b0});
    endtask

    task automatic run_queue(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge Clock);
            IR_Out = e.ir; ALU_Flags = e.fl;
            #1;
            check({tag, "_sc"},      64'(SC),      64'(e.sc));
            check({tag, "_ctrl"},    64'(Ctrl),    64'(e.ctrl));
            check({tag, "_halted"},  64'(Halted),  64'(e.halted));
            check({tag, "_illegal"}, 64'(Illegal), 64'(e.ill));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sc"},      64'(SC),      64'(3'd4));
        check({tag, "_ctrl"},    64'(Ctrl),    64'(init_w()));
        check({tag, "_halted"},  64'(Halted),  64'd0);
        check({tag, "_illegal"}, 64'(Illegal), 64'd0);
    endtask

    initial begin
        vecs[0] = '{16'h102A, 4'h0, mk(0, 0, 2, 4'b1000, 0, 0, 0, 0, 0, 1, 1, 0), idle_w(), 1'b0, 1'b0};
        vecs[1] = '{16'h2640, 4'h0, mk(3'b110, 3'b101, 2, 4'b0100, 4'b0100, 0, 0, 0, 0, 1, 0, 0), idle_w(), 1'b0, 1'b0};
        vecs[2] = '{16'h5010, 4'h0, mk(0, 0, 0, 0, 0, 0, 2'b10, 4'b1000, 0, 1, 0, 2'b01), idle_w(), 1'b0, 1'b0};
        vecs[3] = '{16'h5010, 4'h8, idle_w(), idle_w(), 1'b0, 1'b0};
        vecs[4] = '{16'h7C00, 4'h0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                    mk(0, 0, 2, 4'b0001, 0, 1, 0, 0, 0, 0, 2'b10, 0), 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 4'hF, idle_w(), idle_w(), 1'b0, 1'b0};
        vecs[6] = '{16'h6100, 4'h0, mk(3'b101, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), idle_w(), 1'b0, 1'b0};
        vecs[7] = '{16'h3D80, 4'h0, mk(3'b101, 3'b110, 2, 4'b0001, 4'b0111, 0, 0, 0, 0, 1, 0, 0), idle_w(), 1'b0, 1'b0};
        vecs[8] = '{16'h4055, 4'h8, mk(0, 0, 0, 0, 0, 0, 2'b10, 4'b1000, 0, 1, 0, 2'b01), idle_w(), 1'b0, 1'b0};
        vecs[9] = '{16'hF000, 4'h0, idle_w(), idle_w(), 1'b0, 1'b1};

        Reset = 1'b0; IR_Out = 16'h102A; ALU_Flags = 4'h0;
        repeat (2) @(negedge Clock);
        #1;
        check_reset_state("reset_hold");
        Reset = 1'b1;
        #1;
        check("reset_release_sc", 64'(SC), 64'(3'd4));

        // Directed vectors: SC walks 0,1,2[,3] and the EXEC/EXEC2 words match the table.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock); IR_Out = vecs[i].ir; ALU_Flags = vecs[i].fl; #1;
            check($sformatf("vec%0d_fetch_l_sc", i), 64'(SC), 64'(3'd0));
            @(negedge Clock); #1;
            check($sformatf("vec%0d_fetch_h_sc", i), 64'(SC), 64'(3'd1));
            @(negedge Clock); #1;
            check($sformatf("vec%0d_exec_sc", i),      64'(SC),      64'(3'd2));
            check($sformatf("vec%0d_exec_ctrl", i),    64'(Ctrl),    64'(vecs[i].exec_w));
            check($sformatf("vec%0d_exec_illegal", i), 64'(Illegal), 64'(vecs[i].ill));
            if (vecs[i].two) begin
                @(negedge Clock); #1;
                check($sformatf("vec%0d_exec2_sc", i),   64'(SC),   64'(3'd3));
                check($sformatf("vec%0d_exec2_ctrl", i), 64'(Ctrl), 64'(vecs[i].exec2_w));
            end
        end

        // Random instruction stream (no HLT) against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  op;
            logic [15:0] ir;
            op = 4'($urandom_range(0, 14));
            if (op >= 4'h8) op = op + 4'h1;
            ir = {op, 12'($urandom)};
            model_instr(ir, 4'($urandom), 0);
        end
        run_queue("rand");

        // HLT: halted for 20 cycles, then reset from HALT.
        model_instr(16'h8000, 4'h0, 20);
        run_queue("halt");
        Reset = 1'b0; #1;
        check_reset_state("reset_from_halt");

        // Reset mid-EXEC2 of LD.
        @(negedge Clock); Reset = 1'b1;
        IR_Out = 16'h7C00; ALU_Flags = 4'h0;
        repeat (4) @(negedge Clock);
        #1;
        check("ld_exec2_reached_sc", 64'(SC), 64'(3'd3));
        #2; Reset = 1'b0; #1;
        check_reset_state("reset_mid_exec2");

        // Reset mid-fetch, then one instruction to confirm recovery.
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock); #1;
        check("fetch_reached_sc", 64'(SC), 64'(3'd0));
        Reset = 1'b0; #1;
        check_reset_state("reset_mid_fetch");
        @(negedge Clock); Reset = 1'b1;
        model_instr(16'h2640, 4'h0, 0);
        run_queue("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
